drink_arbiter: RTL and testbench
================================

# drink_arbiter

Two-slot vending front end that shares one drink dispenser between two customer coin slots (A and B). Each slot accumulates coin credit; when a slot reaches the price, a round-robin arbiter grants the dispenser to it, runs a request/acknowledge handshake, and returns the drink pulse and change. It sits between the coin acceptors and the single dispenser/change mechanism. Timeout and cancel paths refund credit.

## Interface
- PRICE, 3, drink price in coin units; legal range 1..6.
- TIMEOUT, 15, max cycles to wait for disp_ack; legal range 1..255.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_a, coin_b  in  2  coin inserted this cycle: 0 none, 1 one unit, 2 two units, 3 invalid (ignored).
- cancel_a, cancel_b  in  1  refund request; level sampled every cycle.
- disp_ack  in  1  one-cycle pulse from dispenser: drink delivered.
- coin_ok_a, coin_ok_b  out  1  slot accepts coins (combinational from registers).
- disp_req  out  1  dispenser request, held high until ack or timeout.
- disp_sel  out  1  slot being served: 0 = A, 1 = B; valid while disp_req = 1.
- drink_a, drink_b  out  1  one-cycle pulse: drink delivered to slot.
- change_a, change_b  out  3  change amount; valid only with change_valid_x.
- change_valid_a, change_valid_b  out  1  one-cycle pulse: change_x is returned.
- fault  out  1  one-cycle pulse: dispenser timeout.

## Operation
- Per-slot 3-bit credit register. Slot pending when credit >= PRICE.
- coin_ok_x = (credit_x < PRICE) and slot not currently granted. Coins with coin_ok_x = 0, or coin = 3, are ignored (not added).
- Accepted coin: credit_x <= credit_x + coin_x. Max credit is PRICE+1 <= 7; no overflow possible.
- Arbiter FSM states: IDLE, SERVE_A, SERVE_B.
- IDLE: pending slots with cancel low are eligible. One eligible -> grant it. Both -> grant the slot that is not last_served. Grant updates last_served.
- SERVE_x: disp_req = 1, disp_sel = x, timeout counter increments each cycle.
  - disp_ack = 1 -> drink_x pulse, change_x = credit_x - PRICE, change_valid_x = 1 only if change is nonzero, credit_x <= 0, go to IDLE.
  - Counter reaches TIMEOUT without ack -> fault pulse, change_x = credit_x (full refund), change_valid_x = 1, credit_x <= 0, go to IDLE.
  - cancel_x is ignored while the slot is served.
- Cancel on a slot not being served: refund credit_x plus any coin accepted in the same cycle. change_valid_x only if the sum is nonzero. Credit is cleared.
- disp_ack outside SERVE states is ignored.
- The slot not being served continues to accept coins and cancels normally.

## Timing
- All outputs except coin_ok_x are registered.
- Coin sampled at edge N -> credit updated after N; pending visible in cycle N+1.
- Pending in IDLE at edge M -> disp_req = 1 from cycle M+1.
- disp_ack sampled high at edge K -> drink_x / change pulses in cycle K+1; disp_req = 0 in K+1; FSM in IDLE in K+1. There is at least one IDLE cycle between grants.
- Timeout: disp_req is high for exactly TIMEOUT cycles. Then fault and refund pulse in the next cycle, with disp_req = 0.
- Cancel sampled at edge N -> change pulse in cycle N+1.
- Reset state:
  - credits 0, FSM IDLE, last_served = B (A wins the first tie), timeout counter 0.
  - all registered outputs 0.
  - coin_ok_a = coin_ok_b = 1.
- Reset mid-service: the transaction is abandoned with no drink and no refund. disp_req drops in the cycle after the reset edge.

## Test plan
- Slot A with PRICE=3: coins 2 then 2, ack 3 cycles after disp_req rises -> disp_req = 1, disp_sel = 0; then drink_a = 1, change_a = 1, change_valid_a = 1 for one cycle; credit_a = 0.
- Slot A: coins 1, 1, 1 -> coin_ok_a falls after the third coin. A fourth coin while coin_ok_a = 0 is ignored. On ack -> drink_a = 1, change_valid_a = 0.
- Both slots reach 3 in the same cycle after reset -> A served first. B is granted after A's ack plus one IDLE cycle. On the next tie, B wins (round-robin).
- Slot B credit 4, no ack -> disp_req high for 15 cycles, then fault = 1, change_b = 4, change_valid_b = 1, and slot B accepts coins again.
- Slot A credit 1, cancel_a together with coin_a = 1 -> change_a = 2 next cycle, credit_a = 0, no grant. Cancel_b during SERVE_B is ignored.
- Assert rst during SERVE_A -> all outputs 0 and credits 0 in the next cycle; a disp_ack arriving afterwards produces no drink pulse.

Source files
------------

// File: rtl/drink_arbiter.sv
// Two coin slots sharing one drink dispenser: per-slot credit, round-robin
// grant, request/ack handshake with timeout refund, and cancel refunds.
module drink_arbiter #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  input  logic       cancel_a,
  input  logic       cancel_b,
  input  logic       disp_ack,
  output logic       coin_ok_a,
  output logic       coin_ok_b,
  output logic       disp_req,
  output logic       disp_sel,
  output logic       drink_a,
  output logic       drink_b,
  output logic [2:0] change_a,
  output logic [2:0] change_b,
  output logic       change_valid_a,
  output logic       change_valid_b,
  output logic       fault
);
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  localparam logic [2:0] PRICE_U  = 3'(PRICE);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_next;
  logic       r_last_served, w_last_served_next;
  logic [7:0] r_tmo_cnt, w_tmo_cnt_next;
  logic [2:0] r_credit [2];
  logic [2:0] w_credit_next [2];

  logic       r_disp_req, w_disp_req_next;
  logic       r_disp_sel, w_disp_sel_next;
  logic [1:0] r_drink, w_drink_next;
  logic [1:0] r_change_valid, w_change_valid_next;
  logic [2:0] r_change [2];
  logic [2:0] w_change_next [2];
  logic       r_fault, w_fault_next;

  // Slot index 0 is A, 1 is B throughout.
  logic [1:0] w_coin [2];
  logic [1:0] w_cancel;
  logic [1:0] w_served;
  logic [1:0] w_pending;
  logic [1:0] w_coin_ok;
  logic [1:0] w_eligible;
  logic [2:0] w_add [2];
  logic [2:0] w_refund [2];
  logic [2:0] w_change_due [2];
  logic       w_slot;

  assign w_coin[0] = coin_a;
  assign w_coin[1] = coin_b;
  assign w_cancel  = {cancel_b, cancel_a};
  assign w_served  = {r_state == SERVE_B, r_state == SERVE_A};
  assign w_slot    = (r_state == SERVE_B);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign w_pending[gi]    = (r_credit[gi] >= PRICE_U);
      assign w_coin_ok[gi]    = !w_pending[gi] && !w_served[gi];
      assign w_add[gi]        = (w_coin_ok[gi] && w_coin[gi] != 2'd3) ? {1'b0, w_coin[gi]} : 3'd0;
      // Credit stays below PRICE when a coin is accepted, so the sum fits in 3 bits.
      assign w_refund[gi]     = r_credit[gi] + w_add[gi];
      assign w_change_due[gi] = r_credit[gi] - PRICE_U;
      assign w_eligible[gi]   = w_pending[gi] && !w_cancel[gi];
    end
  endgenerate

  always_comb begin
    w_state_next        = r_state;
    w_last_served_next  = r_last_served;
    w_tmo_cnt_next      = '0;
    w_drink_next        = '0;
    w_change_valid_next = '0;
    w_fault_next        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_credit_next[i] = r_credit[i];
      w_change_next[i] = '0;
    end

    // Slots not under service take coins and cancels independently.
    for (int i = 0; i < 2; i++) begin
      if (!w_served[i]) begin
        if (w_cancel[i]) begin
          w_credit_next[i]       = '0;
          w_change_next[i]       = w_refund[i];
          w_change_valid_next[i] = (w_refund[i] != 3'd0);
        end else begin
          w_credit_next[i] = w_refund[i];
        end
      end
    end

    case (r_state)
      IDLE: begin
        if (w_eligible[0] && (!w_eligible[1] || r_last_served)) begin
          w_state_next       = SERVE_A;
          w_last_served_next = 1'b0;
        end else if (w_eligible[1]) begin
          w_state_next       = SERVE_B;
          w_last_served_next = 1'b1;
        end
      end
      SERVE_A, SERVE_B: begin
        if (disp_ack) begin
          w_drink_next[w_slot]        = 1'b1;
          w_change_next[w_slot]       = w_change_due[w_slot];
          w_change_valid_next[w_slot] = (w_change_due[w_slot] != 3'd0);
          w_credit_next[w_slot]       = '0;
          w_state_next                = IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_fault_next                = 1'b1;
          w_change_next[w_slot]       = r_credit[w_slot];
          w_change_valid_next[w_slot] = 1'b1;
          w_credit_next[w_slot]       = '0;
          w_state_next                = IDLE;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_disp_req_next = (w_state_next != IDLE);
    w_disp_sel_next = (w_state_next == SERVE_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_served  <= 1'b1;
      r_tmo_cnt      <= '0;
      r_credit       <= '{3'd0, 3'd0};
      r_disp_req     <= 1'b0;
      r_disp_sel     <= 1'b0;
      r_drink        <= '0;
      r_change_valid <= '0;
      r_change       <= '{3'd0, 3'd0};
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_last_served  <= w_last_served_next;
      r_tmo_cnt      <= w_tmo_cnt_next;
      r_credit       <= w_credit_next;
      r_disp_req     <= w_disp_req_next;
      r_disp_sel     <= w_disp_sel_next;
      r_drink        <= w_drink_next;
      r_change_valid <= w_change_valid_next;
      r_change       <= w_change_next;
      r_fault        <= w_fault_next;
    end
  end

  assign coin_ok_a      = w_coin_ok[0];
  assign coin_ok_b      = w_coin_ok[1];
  assign disp_req       = r_disp_req;
  assign disp_sel       = r_disp_sel;
  assign drink_a        = r_drink[0];
  assign drink_b        = r_drink[1];
  assign change_a       = r_change[0];
  assign change_b       = r_change[1];
  assign change_valid_a = r_change_valid[0];
  assign change_valid_b = r_change_valid[1];
  assign fault          = r_fault;
endmodule

// File: tb/tb_drink_arbiter.sv
// Bench for drink_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level model of credits and the dispenser.
module tb_drink_arbiter;
  localparam int PRICE   = 3;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin_a = '0, coin_b = '0;
  logic       cancel_a = 1'b0, cancel_b = 1'b0, disp_ack = 1'b0;
  logic       coin_ok_a, coin_ok_b, disp_req, disp_sel, drink_a, drink_b;
  logic [2:0] change_a, change_b;
  logic       change_valid_a, change_valid_b, fault;

  always #5 clk = ~clk;

  drink_arbiter #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .coin_a(coin_a), .coin_b(coin_b),
    .cancel_a(cancel_a), .cancel_b(cancel_b), .disp_ack(disp_ack),
    .coin_ok_a(coin_ok_a), .coin_ok_b(coin_ok_b),
    .disp_req(disp_req), .disp_sel(disp_sel),
    .drink_a(drink_a), .drink_b(drink_b),
    .change_a(change_a), .change_b(change_b),
    .change_valid_a(change_valid_a), .change_valid_b(change_valid_b),
    .fault(fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: credit per slot, which slot owns the dispenser (-1 none),
  // how long it has waited for ack, and who was granted last.
  int m_credit [2];
  int m_busy;
  int m_wait;
  int m_last;
  int e_req, e_sel, e_fault;
  int e_drink [2];
  int e_chg [2];
  int e_cv [2];

  task automatic check1(input string tag, input logic obs, input int exp);
    n_cmp++;
    assert (obs === 1'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] obs, input int exp);
    n_cmp++;
    assert (obs === 3'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input int ca, input int cb, input bit xa,
                                     input bit xb, input bit ak, input bit r);
    int cn [2];
    bit cx [2];
    bit elig [2];
    int busy0, acc, sum;
    cn[0] = ca; cn[1] = cb; cx[0] = xa; cx[1] = xb;
    e_fault = 0;
    for (int i = 0; i < 2; i++) begin
      e_drink[i] = 0; e_chg[i] = 0; e_cv[i] = 0;
    end
    if (r) begin
      m_credit[0] = 0; m_credit[1] = 0;
      m_busy = -1; m_wait = 0; m_last = 1;
      e_req = 0; e_sel = 0;
      return;
    end
    busy0 = m_busy;
    for (int i = 0; i < 2; i++)
      elig[i] = (busy0 < 0) && (m_credit[i] >= PRICE) && !cx[i];
    if (busy0 >= 0) begin
      m_wait++;
      if (ak) begin
        e_drink[busy0] = 1;
        e_chg[busy0] = m_credit[busy0] - PRICE;
        e_cv[busy0] = (e_chg[busy0] != 0);
        m_credit[busy0] = 0;
        m_busy = -1;
      end else if (m_wait == TIMEOUT) begin
        e_fault = 1;
        e_chg[busy0] = m_credit[busy0];
        e_cv[busy0] = 1;
        m_credit[busy0] = 0;
        m_busy = -1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (i != busy0) begin
        acc = (m_credit[i] < PRICE && cn[i] != 3) ? cn[i] : 0;
        if (cx[i]) begin
          sum = m_credit[i] + acc;
          e_chg[i] = sum; e_cv[i] = (sum != 0);
          m_credit[i] = 0;
        end else begin
          m_credit[i] += acc;
        end
      end
    end
    if (elig[0] || elig[1]) begin
      if (elig[0] && elig[1]) m_busy = 1 - m_last;
      else m_busy = elig[0] ? 0 : 1;
      m_last = m_busy;
      m_wait = 0;
    end
    e_req = (m_busy >= 0);
    e_sel = (m_busy >= 0) ? m_busy : 0;
  endfunction

  task automatic check_all();
    check1("disp_req", disp_req, e_req);
    if (e_req != 0) check1("disp_sel", disp_sel, e_sel);
    check1("drink_a", drink_a, e_drink[0]);
    check1("drink_b", drink_b, e_drink[1]);
    check1("change_valid_a", change_valid_a, e_cv[0]);
    check1("change_valid_b", change_valid_b, e_cv[1]);
    if (e_cv[0] != 0) check3("change_a", change_a, e_chg[0]);
    if (e_cv[1] != 0) check3("change_b", change_b, e_chg[1]);
    check1("fault", fault, e_fault);
    check1("coin_ok_a", coin_ok_a, int'(m_credit[0] < PRICE && m_busy != 0));
    check1("coin_ok_b", coin_ok_b, int'(m_credit[1] < PRICE && m_busy != 1));
  endtask

  task automatic cyc(input int ca, input int cb, input bit xa, input bit xb,
                     input bit ak, input bit r);
    coin_a = 2'(ca); coin_b = 2'(cb);
    cancel_a = xa; cancel_b = xb; disp_ack = ak; rst = r;
    @(posedge clk);
    model_step(ca, cb, xa, xb, ak, r);
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check1("rst_coin_ok_a", coin_ok_a, 1);
    check1("rst_coin_ok_b", coin_ok_b, 1);
    check1("rst_disp_req", disp_req, 0);

    // Slot A: 2 + 2, ack three cycles after request
    cyc(2, 0, 0, 0, 0, 0);
    cyc(2, 0, 0, 0, 0, 0);
    check1("s1_coin_ok_low", coin_ok_a, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s1_req", disp_req, 1);
    check1("s1_sel", disp_sel, 0);
    idle_n(2);
    cyc(0, 0, 0, 0, 1, 0);
    check1("s1_drink_a", drink_a, 1);
    check3("s1_change_a", change_a, 1);
    check1("s1_cv_a", change_valid_a, 1);
    check1("s1_req_drop", disp_req, 0);
    idle_n(1);
    check1("s1_drink_a_pulse", drink_a, 0);
    check1("s1_coin_ok_back", coin_ok_a, 1);

    // Slot A: exact price, fourth coin ignored
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check1("s2_coin_ok_low", coin_ok_a, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check1("s2_req", disp_req, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check1("s2_drink_a", drink_a, 1);
    check1("s2_no_change", change_valid_a, 0);
    idle_n(1);

    // Tie after reset: A first, B after one idle cycle, then round-robin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(2, 2, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s3_first_sel_a", disp_sel, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check1("s3_gap", disp_req, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s3_req_b", disp_req, 1);
    check1("s3_sel_b", disp_sel, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check1("s3_drink_b", drink_b, 1);
    idle_n(1);
    cyc(2, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle_n(1);
    cyc(2, 2, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s3_rr_sel_b", disp_sel, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s3_rr_sel_a", disp_sel, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle_n(1);

    // Slot B timeout: request held exactly TIMEOUT cycles, full refund
    cyc(0, 2, 0, 0, 0, 0);
    cyc(0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check1("s4_req_held", disp_req, 1);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check1("s4_fault", fault, 1);
    check3("s4_change_b", change_b, 4);
    check1("s4_cv_b", change_valid_b, 1);
    check1("s4_req_drop", disp_req, 0);
    check1("s4_coin_ok_b", coin_ok_b, 1);
    idle_n(1);

    // Cancel with a same-cycle coin; cancel ignored while being served
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check3("s5_change_a", change_a, 2);
    check1("s5_cv_a", change_valid_a, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check1("s5_no_grant", disp_req, 0);
    cyc(0, 2, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check1("s5_cancel_ignored", disp_req, 1);
    cyc(0, 0, 0, 1, 1, 0);
    check1("s5_drink_b", drink_b, 1);
    idle_n(1);

    // Reset in the middle of serving A
    cyc(2, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check1("s6_req_drop", disp_req, 0);
    check1("s6_coin_ok_a", coin_ok_a, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check1("s6_no_drink", drink_a, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int ca, cb;
      bit xa, xb, ak, r;
      ca = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      cb = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      xa = ($urandom_range(0, 15) == 0);
      xb = ($urandom_range(0, 15) == 0);
      ak = ($urandom_range(0, 6) == 0);
      r  = ($urandom_range(0, 399) == 0);
      cyc(ca, cb, xa, xb, ak, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
